// File: rtl/fir_slicer_pam4_if.sv
// rtl/fir_slicer_pam4_if.sv - sample stream in, FIR/PAM4 decision stream out
interface fir_slicer_pam4_if #(
  parameter int NB_IN  = 18,
  parameter int NB_OUT = 18
);
  logic                     i_enable;
  logic                     i_valid;
  logic signed [NB_IN-1:0]  i_sample;
  logic signed [NB_OUT-1:0] o_fir;
  logic signed [NB_OUT-1:0] o_slicer;
  logic [1:0]               o_gray_level;

  modport master (
    output i_enable, i_valid, i_sample,
    input  o_fir, o_slicer, o_gray_level
  );

  modport slave (
    input  i_enable, i_valid, i_sample,
    output o_fir, o_slicer, o_gray_level
  );
endinterface

// File: rtl/fir_slicer_pam4.sv
// rtl/fir_slicer_pam4.sv - FIR equaliser followed by a registered PAM4 slicer with Gray output
module fir_slicer_pam4 #(
  parameter int FIR_LEN   = 21,
  parameter int NB_COEFF  = 8,
  parameter int NBF_COEFF = 7,
  parameter int NB_IN     = 18,
  parameter int NBF_IN    = 15,
  parameter int NB_OUT    = 18,
  parameter int NBF_OUT   = 15,
  parameter logic [FIR_LEN*NB_COEFF-1:0] COEFFS =
    {{((FIR_LEN-1)*NB_COEFF){1'b0}}, NB_COEFF'(1 << (NBF_COEFF-1))}
) (
  input  logic               i_clock,
  input  logic               i_reset,
  fir_slicer_pam4_if.slave   bus
);

  localparam int NB_PROD = NB_IN + NB_COEFF;
  localparam int NB_ACC  = NB_PROD + $clog2(FIR_LEN);
  localparam int SHIFT   = NBF_IN + NBF_COEFF - NBF_OUT;

  localparam logic signed [NB_ACC-1:0] SAT_HI = {{(NB_ACC-NB_OUT+1){1'b0}}, {(NB_OUT-1){1'b1}}};
  localparam logic signed [NB_ACC-1:0] SAT_LO = {{(NB_ACC-NB_OUT+1){1'b1}}, {(NB_OUT-1){1'b0}}};
  localparam logic signed [NB_OUT-1:0] OUT_HI = {1'b0, {(NB_OUT-1){1'b1}}};
  localparam logic signed [NB_OUT-1:0] OUT_LO = {1'b1, {(NB_OUT-1){1'b0}}};

  localparam logic signed [NB_OUT-1:0] LVL_1 = NB_OUT'(1 << NBF_OUT);
  localparam logic signed [NB_OUT-1:0] LVL_3 = NB_OUT'(3 << NBF_OUT);
  localparam logic signed [NB_OUT-1:0] THR   = NB_OUT'(2 << NBF_OUT);

  logic signed [NB_IN-1:0]    dly  [FIR_LEN-1];
  logic signed [NB_IN-1:0]    taps [FIR_LEN];
  logic signed [NB_COEFF-1:0] coef;
  logic signed [NB_PROD-1:0]  prod;
  logic signed [NB_ACC-1:0]   acc;
  logic signed [NB_ACC-1:0]   acc_q;
  logic signed [NB_OUT-1:0]   fir_next;
  logic signed [NB_OUT-1:0]   slice_next;
  logic [1:0]                 gray_next;
  logic                       advance;

  assign advance = bus.i_enable & bus.i_valid;

  // Tap 0 is the live input; older samples come from the delay line.
  always_comb begin
    taps[0] = bus.i_sample;
    for (int k = 1; k < FIR_LEN; k++) begin
      taps[k] = dly[k-1];
    end
  end

  // Full-precision products; accumulator is wide enough that no tap sum can overflow.
  always_comb begin
    acc  = '0;
    coef = '0;
    prod = '0;
    for (int k = 0; k < FIR_LEN; k++) begin
      coef = COEFFS[k*NB_COEFF +: NB_COEFF];
      prod = NB_PROD'(taps[k]) * NB_PROD'(coef);
      acc  = acc + NB_ACC'(prod);
    end
  end

  always_comb begin
    acc_q = acc >>> SHIFT;
    if (acc_q > SAT_HI) begin
      fir_next = OUT_HI;
    end else if (acc_q < SAT_LO) begin
      fir_next = OUT_LO;
    end else begin
      fir_next = acc_q[NB_OUT-1:0];
    end
  end

  // Thresholds at 0 and +/-2.0; ties go to the upper level.
  always_comb begin
    slice_next = -LVL_3;
    gray_next  = 2'b00;
    if (bus.o_fir >= THR) begin
      slice_next = LVL_3;
      gray_next  = 2'b10;
    end else if (!bus.o_fir[NB_OUT-1]) begin
      slice_next = LVL_1;
      gray_next  = 2'b11;
    end else if (bus.o_fir >= -THR) begin
      slice_next = -LVL_1;
      gray_next  = 2'b01;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < FIR_LEN-1; k++) begin
        dly[k] <= '0;
      end
      bus.o_fir        <= '0;
      bus.o_slicer     <= '0;
      bus.o_gray_level <= 2'b00;
    end else if (advance) begin
      dly[0] <= bus.i_sample;
      for (int k = 1; k < FIR_LEN-1; k++) begin
        dly[k] <= dly[k-1];
      end
      bus.o_fir        <= fir_next;
      bus.o_slicer     <= slice_next;
      bus.o_gray_level <= gray_next;
    end
  end

endmodule

// File: tb/tb_fir_slicer_pam4.sv
// tb/tb_fir_slicer_pam4.sv - directed checks of fir_slicer_pam4 with three coefficient sets
module tb_fir_slicer_pam4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               en  = 1'b0;
  logic               val = 1'b0;
  logic signed [17:0] smp = '0;
  int                 checks = 0;
  int                 errors = 0;

  always #5 clk = ~clk;

  fir_slicer_pam4_if #(.NB_IN(18), .NB_OUT(18)) bus_a ();
  fir_slicer_pam4_if #(.NB_IN(18), .NB_OUT(18)) bus_b ();
  fir_slicer_pam4_if #(.NB_IN(18), .NB_OUT(18)) bus_c ();

  assign bus_a.i_enable = en;
  assign bus_a.i_valid  = val;
  assign bus_a.i_sample = smp;
  assign bus_b.i_enable = en;
  assign bus_b.i_valid  = val;
  assign bus_b.i_sample = smp;
  assign bus_c.i_enable = en;
  assign bus_c.i_valid  = val;
  assign bus_c.i_sample = smp;

  // a: default taps (tap0 = 0.5); b: tap0 = -1.0; c: all 21 taps = 127/128
  fir_slicer_pam4 dut_a (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus_a)
  );

  fir_slicer_pam4 #(.COEFFS({{20{8'h00}}, 8'h80})) dut_b (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus_b)
  );

  fir_slicer_pam4 #(.COEFFS({21{8'h7F}})) dut_c (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus_c)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst_a_fir",   bus_a.o_fir, 0);
    check("rst_a_slc",   bus_a.o_slicer, 0);
    check("rst_a_gray",  bus_a.o_gray_level, 0);
    check("rst_c_fir",   bus_c.o_fir, 0);
    run(2);
    rst = 1'b0;

    // single +1.0 then zeros
    en = 1'b1; val = 1'b1; smp = 18'h08000;
    step();
    check("imp_fir0", bus_a.o_fir, 16384);
    smp = 18'h00000;
    step();
    check("imp_fir1", bus_a.o_fir, 0);
    check("imp_slc1", bus_a.o_slicer, 32768);
    check("imp_gry1", bus_a.o_gray_level, 3);
    step();
    check("imp_slc2", bus_a.o_slicer, 32768);
    check("imp_gry2", bus_a.o_gray_level, 3);

    // constant +3.0 and -3.0
    smp = 18'h18000;
    run(2);
    check("p3_fir", bus_a.o_fir, 49152);
    check("p3_slc", bus_a.o_slicer, 32768);
    check("p3_gry", bus_a.o_gray_level, 3);
    smp = 18'h28000;
    run(2);
    check("m3_fir", bus_a.o_fir, -49152);
    check("m3_slc", bus_a.o_slicer, -32768);
    check("m3_gry", bus_a.o_gray_level, 1);

    // -4.0 held long enough to fill every tap of dut_c
    smp = 18'h20000;
    run(22);
    check("m4_a_fir", bus_a.o_fir, -65536);
    check("m4_a_slc", bus_a.o_slicer, -32768);
    check("m4_a_gry", bus_a.o_gray_level, 1);
    check("sat_b_fir", bus_b.o_fir, 131071);
    check("sat_b_slc", bus_b.o_slicer, 98304);
    check("sat_b_gry", bus_b.o_gray_level, 2);
    check("sat_c_fir", bus_c.o_fir, -131072);
    check("sat_c_slc", bus_c.o_slicer, -98304);
    check("sat_c_gry", bus_c.o_gray_level, 0);

    smp = 18'h00000;
    run(2);
    check("z_a_fir", bus_a.o_fir, 0);
    check("z_a_slc", bus_a.o_slicer, 32768);
    check("z_a_gry", bus_a.o_gray_level, 3);
    check("z_b_gry", bus_b.o_gray_level, 3);

    smp = 18'h1FFFF;
    run(2);
    check("max_a_fir", bus_a.o_fir, 65535);
    check("max_a_slc", bus_a.o_slicer, 32768);
    check("max_a_gry", bus_a.o_gray_level, 3);
    check("max_b_fir", bus_b.o_fir, -131071);
    check("max_b_gry", bus_b.o_gray_level, 0);

    // exact +2.0 and -2.0 ties on dut_b
    smp = 18'h30000;
    run(2);
    check("tie_p2_fir", bus_b.o_fir, 65536);
    check("tie_p2_slc", bus_b.o_slicer, 98304);
    check("tie_p2_gry", bus_b.o_gray_level, 2);
    check("m2_a_gry",   bus_a.o_gray_level, 1);
    smp = 18'h10000;
    run(2);
    check("tie_m2_fir", bus_b.o_fir, -65536);
    check("tie_m2_slc", bus_b.o_slicer, -32768);
    check("tie_m2_gry", bus_b.o_gray_level, 1);
    check("p2_a_fir",   bus_a.o_fir, 32768);

    // asynchronous reset between edges
    step();
    #1 rst = 1'b1;
    #1;
    check("arst_a_fir", bus_a.o_fir, 0);
    check("arst_b_fir", bus_b.o_fir, 0);
    check("arst_b_slc", bus_b.o_slicer, 0);
    check("arst_b_gry", bus_b.o_gray_level, 0);
    check("arst_c_fir", bus_c.o_fir, 0);
    smp = 18'h08000;
    #1 rst = 1'b0;

    // impulse through dut_c: 21 advances of 32512, with a stall in the middle
    step();
    check("flush_c_fir", bus_c.o_fir, 32512);
    check("flush_a_fir", bus_a.o_fir, 16384);
    smp = 18'h00000;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin
        val = 1'b0; smp = 18'h10000;
        step();
        check("stl1_c_fir", bus_c.o_fir, 32512);
        check("stl1_a_fir", bus_a.o_fir, 0);
        step();
        check("stl2_c_gry", bus_c.o_gray_level, 3);
        val = 1'b1; en = 1'b0;
        step();
        check("stl3_c_fir", bus_c.o_fir, 32512);
        check("stl3_a_fir", bus_a.o_fir, 0);
        en = 1'b1; smp = 18'h00000;
      end
      step();
    end
    check("tail_c_fir", bus_c.o_fir, 32512);
    check("tail_c_slc", bus_c.o_slicer, 32768);
    check("tail_c_gry", bus_c.o_gray_level, 3);
    step();
    check("end_c_fir", bus_c.o_fir, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
